// File: rtl/uni_shift_seq.sv
// Universal multi-mode shift register: a start launches `amount` 1-bit steps, then done pulses for one cycle with the final value.
// Latency is amount cycles (amount==0 completes the next cycle); start/load are dropped while busy, with no queuing or backpressure.
module uni_shift_seq #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [N-1:0]     data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             ser_in,
  output logic [N-1:0]     data_out,
  output logic             busy,
  output logic             done,
  output logic             ser_out_msb,
  output logic             ser_out_lsb
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    M_LSL  = 3'b000,
    M_LSR  = 3'b001,
    M_ASR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_SSL  = 3'b101,
    M_SSR  = 3'b110,
    M_HOLD = 3'b111
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q,  mode_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N-1:0]     data_q,  data_d;
  logic             done_q,  done_d;
  logic [N-1:0]     step_val;

  // One 1-bit step of the latched operation; reserved mode holds the value.
  always_comb begin
    step_val = data_q;
    case (mode_q)
      M_LSL:   step_val = {data_q[N-2:0], 1'b0};
      M_LSR:   step_val = {1'b0, data_q[N-1:1]};
      M_ASR:   step_val = {data_q[N-1], data_q[N-1:1]};
      M_ROL:   step_val = {data_q[N-2:0], data_q[N-1]};
      M_ROR:   step_val = {data_q[0], data_q[N-1:1]};
      M_SSL:   step_val = {data_q[N-2:0], ser_in};
      M_SSR:   step_val = {ser_in, data_q[N-1:1]};
      default: step_val = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          data_d = data_in;
        end else if (start) begin
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode_t'(mode);
            cnt_d   = amount;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // start/load are deliberately not looked at here.
        data_d = step_val;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= M_LSL;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign data_out    = data_q;
  assign busy        = (state_q == SHIFT);
  assign done        = done_q;
  assign ser_out_msb = data_q[N-1];
  assign ser_out_lsb = data_q[0];

endmodule

// File: tb/tb_uni_shift_seq.sv
// Directed bench for uni_shift_seq: arithmetic reference model checked every cycle plus literal expectations.
module tb_uni_shift_seq;
  localparam int N     = 8;
  localparam int CNT_W = 4;
  localparam int MASK  = (1 << N) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             load;
  logic [N-1:0]     data_in;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             ser_in;
  logic [N-1:0]     data_out;
  logic             busy;
  logic             done;
  logic             ser_out_msb;
  logic             ser_out_lsb;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state: value, steps still owed, pending done.
  int m_data = 0;
  int m_rem  = 0;
  int m_mode = 0;
  bit m_done = 1'b0;

  logic [N-1:0] hist [40];

  uni_shift_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .data_in     (data_in),
    .start       (start),
    .mode        (mode),
    .amount      (amount),
    .ser_in      (ser_in),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .ser_out_msb (ser_out_msb),
    .ser_out_lsb (ser_out_lsb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_step(input int d, input int md, input int s);
    case (md)
      0:       return (d * 2) & MASK;
      1:       return d / 2;
      2:       return (d / 2) | (d & (1 << (N - 1)));
      3:       return ((d * 2) & MASK) | (d >> (N - 1));
      4:       return (d / 2) | ((d % 2) << (N - 1));
      5:       return ((d * 2) & MASK) | s;
      6:       return (d / 2) | (s << (N - 1));
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_data = 0;
      m_rem  = 0;
      m_mode = 0;
      m_done = 1'b0;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (load) begin
        m_data = int'(data_in);
      end else if (start) begin
        if (amount == 0) m_done = 1'b1;
        else begin
          m_mode = int'(mode);
          m_rem  = int'(amount);
        end
      end
    end else begin
      m_data = model_step(m_data, m_mode, int'(ser_in));
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data",    int'(data_out),    m_data);
      chk("m_busy",    int'(busy),        int'(m_rem != 0));
      chk("m_done",    int'(done),        int'(m_done));
      chk("m_msb",     int'(ser_out_msb), (m_data >> (N - 1)) & 1);
      chk("m_lsb",     int'(ser_out_lsb), m_data & 1);
      chk("busy_done", int'(busy && done), 0);
    end
  end

  task automatic do_load(input logic [N-1:0] v);
    load = 1'b1;
    data_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Launch an operation, scramble mode/amount after the start edge, feed ser_in per busy cycle.
  task automatic run_op(input logic [2:0] md, input logic [CNT_W-1:0] amt, input logic [15:0] bits,
                        input bit poke, output int bc, output int dn);
    mode = md;
    amount = amt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 3'd7;
    amount = '0;
    bc = 0;
    while (busy && bc < 40) begin
      ser_in = (bc < 16) ? bits[bc] : 1'b0;
      if (poke && bc == 1) begin
        load = 1'b1;
        start = 1'b1;
        data_in = 8'hFF;
        mode = 3'd3;
        amount = 4'd1;
      end
      @(negedge clk);
      load = 1'b0;
      start = 1'b0;
      hist[bc] = data_out;
      bc = bc + 1;
    end
    chk("op_timeout", int'(busy), 0);
    dn = int'(done);
  endtask

  initial begin
    int bc;
    int dn;
    int done_seen;
    reset_n = 1'b0; load = 1'b0; start = 1'b0; data_in = '0;
    mode = '0; amount = '0; ser_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_data", int'(data_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1;

    do_load(8'hA5);
    chk("load_a5", int'(data_out), 8'hA5);
    run_op(3'd0, 4'd3, 16'h0, 1'b0, bc, dn);
    chk("lsl3_cycles", bc, 3);
    chk("lsl3_data", int'(data_out), 8'h28);
    chk("lsl3_done", dn, 1);
    @(negedge clk);
    chk("lsl3_done_one", int'(done), 0);

    do_load(8'h81);
    run_op(3'd2, 4'd2, 16'h0, 1'b0, bc, dn);
    chk("asr2_cycles", bc, 2);
    chk("asr2_data", int'(data_out), 8'hE0);
    chk("asr2_done", dn, 1);

    do_load(8'h81);
    run_op(3'd3, 4'd9, 16'h0, 1'b0, bc, dn);
    chk("rol9_cycles", bc, 9);
    chk("rol9_data", int'(data_out), 8'h03);

    do_load(8'h00);
    run_op(3'd6, 4'd3, 16'h0005, 1'b0, bc, dn);
    chk("ssr_step1", int'(hist[0]), 8'h80);
    chk("ssr_step2", int'(hist[1]), 8'h40);
    chk("ssr_step3", int'(hist[2]), 8'hA0);

    do_load(8'h01);
    run_op(3'd4, 4'd1, 16'h0, 1'b0, bc, dn);
    chk("ror1_data", int'(data_out), 8'h80);
    run_op(3'd5, 4'd2, 16'h0003, 1'b0, bc, dn);
    chk("ssl2_data", int'(data_out), 8'h03);

    do_load(8'hFF);
    run_op(3'd1, 4'd12, 16'h0, 1'b0, bc, dn);
    chk("lsr12_cycles", bc, 12);
    chk("lsr12_data", int'(data_out), 8'h00);

    do_load(8'h99);
    run_op(3'd7, 4'd3, 16'h0, 1'b0, bc, dn);
    chk("hold3_cycles", bc, 3);
    chk("hold3_data", int'(data_out), 8'h99);
    chk("hold3_done", dn, 1);

    // Zero-length operation.
    mode = 3'd0; amount = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("amt0_busy", int'(busy), 0);
    chk("amt0_done", int'(done), 1);
    chk("amt0_data", int'(data_out), 8'h99);
    @(negedge clk);
    chk("amt0_done_one", int'(done), 0);

    // load/start pokes during SHIFT must not disturb result or timing.
    do_load(8'h3C);
    run_op(3'd0, 4'd4, 16'h0, 1'b1, bc, dn);
    chk("poke_cycles", bc, 4);
    chk("poke_data", int'(data_out), 8'hC0);
    chk("poke_done", dn, 1);

    // load wins over a simultaneous start.
    load = 1'b1; data_in = 8'h5A; start = 1'b1; mode = 3'd0; amount = 4'd2;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("ldst_data", int'(data_out), 8'h5A);
    chk("ldst_busy", int'(busy), 0);
    chk("ldst_done", int'(done), 0);
    @(negedge clk);
    chk("ldst_busy2", int'(busy), 0);
    chk("ldst_done2", int'(done), 0);

    // Reset during the 2nd busy cycle of a 5-step shift.
    do_load(8'hFF);
    mode = 3'd1; amount = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy1", int'(busy), 1);
    @(negedge clk);
    chk("mid_busy2", int'(busy), 1);
    chk("mid_data2", int'(data_out), 8'h7F);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_data", int'(data_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    chk("mid_no_done", done_seen, 0);
    do_load(8'h12);
    chk("post_rst_load", int'(data_out), 8'h12);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
